// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin byte scheduler sharing one self-timed UART TX
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 10417,
  parameter int FRAME_BITS   = 11,
  parameter int GAP_CYCLES   = 2,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               frame_done
);

  localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
  localparam int CNT_W      = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_FRAME = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] full;
  logic [7:0]       slot [N_REQ];
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  idx;
  logic [ID_W-1:0]  ptr_next;
  logic             found;
  logic             do_grant;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] grant_clr;
  logic [N_REQ-1:0] full_next;

  // Walk the slots starting at ptr; the first full one wins.
  always_comb begin
    sel   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && full[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  // The last gap cycle doubles as the idle decision so back-to-back frames
  // do not lose a clock in IDLE.
  always_comb begin
    do_grant  = found && ((state == S_IDLE) || (state == S_GAP && cnt == '0));
    ptr_next  = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    grant_clr = do_grant ? (N_REQ'(1) << sel) : '0;
    accept    = req_valid & req_ready;
    full_next = (full & ~grant_clr) | accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      full       <= '0;
      req_ready  <= '1;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot[i] <= '0;
      end
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      full       <= full_next;
      req_ready  <= ~full_next;
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          slot[i] <= req_data[8*i +: 8];
        end
      end

      if (do_grant) begin
        state    <= S_GRANT;
        tx_data  <= slot[sel];
        grant_id <= sel;
        ptr      <= ptr_next;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
          end
          S_GRANT: begin
            state    <= S_START;
            tx_start <= 1'b1;
          end
          S_START: begin
            state <= S_FRAME;
            cnt   <= FRAME_LOAD;
          end
          S_FRAME: begin
            if (cnt == '0) begin
              state      <= S_GAP;
              cnt        <= GAP_LOAD;
              frame_done <= (GAP_CYCLES == 1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_GAP: begin
            if (cnt == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt        <= cnt - 1'b1;
              frame_done <= (cnt == CNT_W'(1));
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : vector table plus scoreboard bench for uart_tx_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N_REQ          = 4;
  localparam int CLKS_PER_BIT   = 4;
  localparam int FRAME_BITS     = 11;
  localparam int GAP_CYCLES     = 2;
  localparam int START_TO_DONE  = FRAME_BITS * CLKS_PER_BIT + GAP_CYCLES;
  localparam int START_TO_START = FRAME_BITS * CLKS_PER_BIT + GAP_CYCLES + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        frame_done;

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FRAME_BITS  (FRAME_BITS),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   start_times[$];
  int   cyc = 0;

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    sbq.push_back(e);
  endtask

  // Every tx_start is matched against the next expected grant.
  initial begin
    exp_t e;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start === 1'b1) begin
        start_times.push_back(cyc);
        check("start_one_cycle", 32'(prev_start), 32'd0);
        check("start_with_busy", 32'(busy), 32'd1);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_start: got id=%0d data=%0h expected no start", grant_id, tx_data);
        end else begin
          e = sbq.pop_front();
          check("sb_grant_id", 32'(grant_id), 32'(e.id));
          check("sb_tx_data", 32'(tx_data), 32'(e.data));
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_starts(input string name, input int want);
    int n;
    n = 0;
    while (start_times.size() < want && n < 1500) begin
      tick();
      n++;
    end
    check(name, 32'(start_times.size()), 32'(want));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int         req;
    logic [7:0] data;
    int         exp_id;
    logic [7:0] exp_data;
    int         exp_lat;
    int         exp_done;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int k0;
    int k3;
    int nstart;
    logic acc0;
    logic acc3;

    vecs[0] = '{2, 8'hA5, 2, 8'hA5, 3, START_TO_DONE};
    vecs[1] = '{0, 8'h3C, 0, 8'h3C, 3, START_TO_DONE};
    vecs[2] = '{3, 8'hFF, 3, 8'hFF, 3, START_TO_DONE};
    vecs[3] = '{1, 8'h00, 1, 8'h00, 3, START_TO_DONE};

    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'hF);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_req_ready", 32'(req_ready), 32'hF);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single requests from the vector table.
    for (int i = 0; i < 4; i++) begin
      wait_idle("idle_before_single");
      req_valid[vecs[i].req] = 1'b1;
      req_data[8*vecs[i].req +: 8] = vecs[i].data;
      push_exp(vecs[i].exp_id, vecs[i].exp_data);
      tick();
      req_valid = '0;
      check("single_slot_full", 32'(req_ready[vecs[i].req]), 32'd0);
      n = 1;
      while (tx_start !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check("single_start_latency", 32'(n), 32'(vecs[i].exp_lat));
      check("single_grant_id", 32'(grant_id), 32'(vecs[i].exp_id));
      check("single_tx_data", 32'(tx_data), 32'(vecs[i].exp_data));
      n = 0;
      while (frame_done !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      check("single_done_latency", 32'(n), 32'(vecs[i].exp_done));
      tick();
      check("single_busy_clear", 32'(busy), 32'd0);
      check("single_done_pulse", 32'(frame_done), 32'd0);
    end

    // All four at once from a fresh pointer.
    do_reset();
    start_times.delete();
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    push_exp(0, 8'h11);
    push_exp(1, 8'h22);
    push_exp(2, 8'h33);
    push_exp(3, 8'h44);
    tick();
    req_valid = '0;
    check("all_slots_full", 32'(req_ready), 32'h0);
    wait_starts("all_four_starts", 4);
    if (start_times.size() >= 4) begin
      for (int k = 0; k < 3; k++) begin
        check("all_start_spacing", 32'(start_times[k+1] - start_times[k]), 32'(START_TO_START));
      end
    end
    wait_idle("idle_after_all");

    // Pointer back at 0: 0 beats 3.
    start_times.delete();
    req_valid = 4'b1001;
    req_data  = 32'h5A00_00A5;
    push_exp(0, 8'hA5);
    push_exp(3, 8'h5A);
    tick();
    req_valid = '0;
    wait_starts("ptr_wrap_starts", 2);
    wait_idle("idle_after_wrap");

    // Fairness: req0 refills immediately, req3 must still alternate in.
    start_times.delete();
    k0 = 0;
    k3 = 0;
    for (int k = 0; k < 3; k++) begin
      push_exp(0, 8'hA0 + 8'(k));
      push_exp(3, 8'hD0 + 8'(k));
    end
    req_valid = 4'b1001;
    req_data  = 32'hD000_00A0;
    n = 0;
    while ((k0 < 3 || k3 < 3) && n < 2000) begin
      acc0 = req_valid[0] & req_ready[0];
      acc3 = req_valid[3] & req_ready[3];
      tick();
      n++;
      if (acc0) begin
        k0++;
        if (k0 < 3) req_data[7:0] = 8'hA0 + 8'(k0);
        else req_valid[0] = 1'b0;
      end
      if (acc3) begin
        k3++;
        if (k3 < 3) req_data[31:24] = 8'hD0 + 8'(k3);
        else req_valid[3] = 1'b0;
      end
    end
    req_valid = '0;
    check("fair_accepts", 32'(k0 + k3), 32'd6);
    wait_starts("fair_starts", 6);
    wait_idle("idle_after_fair");

    // Overrun: second byte held off until the slot frees.
    start_times.delete();
    push_exp(1, 8'h55);
    push_exp(1, 8'h66);
    req_valid[1]    = 1'b1;
    req_data[15:8]  = 8'h55;
    tick();
    check("ovr_full", 32'(req_ready[1]), 32'd0);
    req_data[15:8] = 8'h66;
    tick();
    check("ovr_freed_after_grant", 32'(req_ready[1]), 32'd1);
    check("ovr_grant_data", 32'(tx_data), 32'h55);
    tick();
    check("ovr_start", 32'(tx_start), 32'd1);
    check("ovr_second_taken", 32'(req_ready[1]), 32'd0);
    req_valid = '0;
    repeat (10) tick();
    check("ovr_data_stable", 32'(tx_data), 32'h55);
    wait_starts("ovr_starts", 2);
    wait_idle("idle_after_ovr");

    // Reset mid-frame drops the pending byte.
    start_times.delete();
    push_exp(2, 8'h77);
    req_valid[2]    = 1'b1;
    req_data[23:16] = 8'h77;
    tick();
    req_valid = '0;
    wait_starts("midrst_first_start", 1);
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h88;
    tick();
    req_valid = '0;
    check("midrst_pending_full", 32'(req_ready[0]), 32'd0);
    repeat (18) tick();
    nstart = start_times.size();
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_slots_empty", 32'(req_ready), 32'hF);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    repeat (4) tick();
    reset = 1'b1;
    repeat (120) tick();
    check("midrst_no_restart", 32'(start_times.size()), 32'(nstart));
    check("midrst_idle", 32'(busy), 32'd0);
    check("sb_all_consumed", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
